// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// mem_responder: single-port word memory behind a valid/ready request and
// response handshake, with a fixed, parameterisable access latency.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_we            1 = store, 0 = load
//   req_addr          byte address
//   req_be            store byte enables (ignored for loads)
//   req_wdata         store data
//   rsp_valid/ready   response handshake
//   rsp_rdata         load data (0 for stores and faults)
//   rsp_err           access fault: misaligned or outside the window
module mem_responder #(
  parameter int              X_LEN       = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter longint unsigned BASE_ADDR   = 0,
  parameter int              WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [X_LEN-1:0]   req_addr,
  input  logic [X_LEN/8-1:0] req_be,
  input  logic [X_LEN-1:0]   req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [X_LEN-1:0]   rsp_rdata,
  output logic               rsp_err
);
  localparam int NB    = X_LEN / 8;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Offset math is two bits wider than an address so that an address below
  // the base shows up as a huge unsigned value instead of wrapping into range.
  localparam int              OW     = X_LEN + 2;
  localparam logic [OW-1:0]   BASE_W = OW'(BASE_ADDR);
  localparam logic [OW-1:0]   SPAN_W = OW'(4 * longint'(DEPTH_WORDS));

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic             we;
    logic [X_LEN-1:0] addr;
    logic [NB-1:0]    be;
    logic [X_LEN-1:0] wdata;
  } req_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  req_t             lat_q, lat_d;
  logic [X_LEN-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  req_t             req_in, acc;
  logic [OW-1:0]    off;
  logic             acc_err;
  logic [IDX_W-1:0] idx;
  logic             do_access;
  logic             mem_we;

  // Storage has no reset: contents survive rst.
  logic [X_LEN-1:0] mem [DEPTH_WORDS];

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign req_in = '{we: req_we, addr: req_addr, be: req_be, wdata: req_wdata};
  // With zero wait cycles the access happens on the accept edge itself, so
  // the live request is used; otherwise the latched copy.
  assign acc     = (state_q == IDLE) ? req_in : lat_q;
  assign off     = OW'(acc.addr) - BASE_W;
  assign acc_err = (acc.addr[1:0] != 2'b00) || off[OW-1] || (off >= SPAN_W);
  assign idx     = off[IDX_W+1:2];
  assign mem_we  = do_access && acc.we && !acc_err && !rst;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        lat_d = req_in;
        if (WAIT_CYCLES == 0) begin
          state_d   = RESP;
          do_access = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        state_d   = RESP;
        do_access = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      err_d   = acc_err;
      rdata_d = (!acc.we && !acc_err) ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (acc.be[b]) mem[idx][8*b +: 8] <= acc.wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
// Bench: three responders (wait 1, 3, 0) sharing one clock, each with its own
// handshake signals. A word-array model predicts every response.
module tb_mem_responder;
  localparam int          NI     = 3;
  localparam int          DEPTH  = 64;
  localparam logic [31:0] BASE   = 32'h100;
  localparam longint      BASE_L = 64'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we    [NI];
  logic [31:0] req_addr  [NI];
  logic [3:0]  req_be    [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_responder #(
      .X_LEN(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk(clk), .rst(rst[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_be(req_be[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
    );
  end

  function automatic int wv(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  int errs = 0;
  int checks = 0;
  logic [31:0] model [NI][DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Reference: fault if misaligned or outside [BASE, BASE+4*DEPTH); stores
  // merge enabled bytes into the model word, loads return the model word.
  function automatic void ref_acc(input int k, input bit we, input logic [31:0] a,
                                  input logic [3:0] be, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
    longint la = longint'(a);
    int w;
    er = (a[1:0] != 2'b00) || (la < BASE_L) || (la >= BASE_L + 4 * DEPTH);
    rd = '0;
    if (!er) begin
      w = int'((la - BASE_L) / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[k][w][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rd = model[k][w];
      end
    end
  endfunction

  task automatic xact(input int k, input bit we, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    @(negedge clk);
    while (req_ready[k] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n == 50) chkb("req_ready_timeout", req_ready[k], 1'b1);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = a;
    req_be[k] = be; req_wdata[k] = wd;
    @(posedge clk);
    @(negedge clk);
    // Inputs become don't-care after accept: scramble them.
    req_valid[k] = 1'b0; req_we[k] = 1'($urandom); req_addr[k] = $urandom;
    req_be[k] = 4'($urandom); req_wdata[k] = $urandom;
    lat = 1;
    while (rsp_valid[k] !== 1'b1 && lat < 40) begin
      chkb("busy_ready_low", req_ready[k], 1'b0);
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[k];
    er = rsp_err[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chkb("hold_valid", rsp_valid[k], 1'b1);
      chk("hold_rdata", rsp_rdata[k], rd);
      chkb("hold_err", rsp_err[k], er);
      chkb("hold_ready_low", req_ready[k], 1'b0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chkb("post_hs_valid", rsp_valid[k], 1'b0);
    chkb("post_hs_ready", req_ready[k], 1'b1);
  endtask

  task automatic run(input int k, input bit we, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd, input int hold,
                     input string nm);
    logic [31:0] erd, rd;
    logic eer, er;
    int lat;
    ref_acc(k, we, a, be, wd, erd, eer);
    xact(k, we, a, be, wd, hold, rd, er, lat);
    chk({nm, "_rdata"}, rd, erd);
    chkb({nm, "_err"}, er, eer);
    chk({nm, "_lat"}, 32'(lat), 32'(1 + wv(k)));
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    logic [31:0] rd, dummy_rd, a;
    logic er, dummy_er;
    int lat, r;

    tbl[0]  = '{1, BASE + 32'h8,   4'hF, 32'hDEADBEEF, 32'h0,        0};
    tbl[1]  = '{0, BASE + 32'h8,   4'h0, 32'h0,        32'hDEADBEEF, 0};
    tbl[2]  = '{1, BASE + 32'h8,   4'h2, 32'h00005500, 32'h0,        0};
    tbl[3]  = '{0, BASE + 32'h8,   4'hF, 32'h0,        32'hDEAD55EF, 0};
    tbl[4]  = '{0, BASE + 32'h6,   4'h0, 32'h0,        32'h0,        1};
    tbl[5]  = '{0, BASE + 32'h100, 4'h0, 32'h0,        32'h0,        1};
    tbl[6]  = '{0, BASE - 32'h4,   4'h0, 32'h0,        32'h0,        1};
    tbl[7]  = '{1, BASE + 32'hA,   4'hF, 32'h11111111, 32'h0,        1};
    tbl[8]  = '{1, BASE + 32'h100, 4'hF, 32'h22222222, 32'h0,        1};
    tbl[9]  = '{0, BASE + 32'h8,   4'h0, 32'h0,        32'hDEAD55EF, 0};
    tbl[10] = '{1, BASE + 32'hFC,  4'hF, 32'h11223344, 32'h0,        0};
    tbl[11] = '{1, BASE + 32'hFC,  4'h9, 32'hAABBCCDD, 32'h0,        0};

    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_be[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chkb("rst_req_ready", req_ready[k], 1'b1);
      chkb("rst_rsp_valid", rsp_valid[k], 1'b0);
      chkb("rst_rsp_err", rsp_err[k], 1'b0);
      chk("rst_rsp_rdata", rsp_rdata[k], 32'h0);
    end

    // Give every word a known value so any later load is predictable.
    for (int k = 0; k < NI; k++)
      for (int w = 0; w < DEPTH; w++)
        run(k, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom, 0, "prefill");

    // Directed vectors on the wait-1 instance.
    for (int i = 0; i < 12; i++) begin
      xact(0, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd, 0, rd, er, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chkb($sformatf("tbl%0d_err", i), er, tbl[i].err);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
      ref_acc(0, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wd, dummy_rd, dummy_er);
    end
    xact(0, 1'b0, BASE + 32'hFC, 4'h0, 32'h0, 0, rd, er, lat);
    chk("be_merge_rdata", rd, 32'hAA2233DD);

    // Response held for 5 cycles with rsp_ready low.
    run(0, 1'b0, BASE + 32'h8, 4'h0, 32'h0, 5, "hold5");

    // Reset in the 2nd WAIT cycle of a wait-3 store discards it.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = BASE;
    req_be[1] = 4'hF; req_wdata[1] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chkb("abort_w1_valid", rsp_valid[1], 1'b0);
    @(negedge clk);
    chkb("abort_w2_valid", rsp_valid[1], 1'b0);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    chkb("abort_req_ready", req_ready[1], 1'b1);
    chkb("abort_rsp_valid", rsp_valid[1], 1'b0);
    chkb("abort_rsp_err", rsp_err[1], 1'b0);
    chk("abort_rsp_rdata", rsp_rdata[1], 32'h0);
    repeat (4) begin
      @(negedge clk);
      chkb("abort_no_rsp", rsp_valid[1], 1'b0);
    end
    run(1, 1'b0, BASE, 4'h0, 32'h0, 0, "abort_old_value");

    // Zero-wait instance: store then load of the same word.
    run(2, 1'b1, BASE + 32'h10, 4'hF, 32'hCAFEF00D, 0, "w0_store");
    run(2, 1'b0, BASE + 32'h10, 4'h0, 32'h0, 0, "w0_load");

    // Random traffic on all three instances.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 50; i++) begin
        r = $urandom_range(0, 9);
        a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        if (r == 0) a = a + 32'($urandom_range(1, 3));
        if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        if (r == 2) a = BASE - 32'(4 * $urandom_range(1, 4));
        run(k, 1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 2), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
- REQ-001 SHALL have parameter X_LEN, default 32, meaning the data and address width in bits.
- REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning the storage size in X_LEN-bit words.
- REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning the byte address of word 0.
- REQ-004 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, meaning the extra cycles inserted between request accept and response.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
- REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-007 SHALL have port req_valid, input, 1 bit: core request present.
- REQ-008 SHALL have port req_ready, output, 1 bit: responder can accept a request.
- REQ-009 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
- REQ-010 SHALL have port req_addr, input, X_LEN bits: byte address.
- REQ-011 SHALL have port req_be, input, X_LEN/8 bits: store byte enables.
- REQ-012 SHALL have port req_wdata, input, X_LEN bits: store data.
- REQ-013 SHALL have port rsp_valid, output, 1 bit: response present.
- REQ-014 SHALL have port rsp_ready, input, 1 bit: core accepts the response.
- REQ-015 SHALL have port rsp_rdata, output, X_LEN bits: load data.
- REQ-016 SHALL have port rsp_err, output, 1 bit: access fault.

Function
- REQ-017 SHALL implement an FSM with states IDLE, WAIT and RESP.
- REQ-018 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
- REQ-019 SHALL latch req_we, req_addr, req_be and req_wdata on accept, so the inputs are don't-care afterwards.
- REQ-020 SHALL transition on accept from IDLE to WAIT with wait counter = WAIT_CYCLES-1 if WAIT_CYCLES>0, else go directly to RESP.
- REQ-021 SHALL decrement the counter in WAIT and go to RESP on the edge where the counter equals 0.
- REQ-022 SHALL perform the access on the edge that enters RESP, so rsp_valid rises exactly 1+WAIT_CYCLES cycles after the accept edge.
- REQ-023 SHALL set the word index to (latched addr - BASE_ADDR) >> 2 (X_LEN=32).
- REQ-024 SHALL, for a store, write only the bytes whose req_be bit is 1; all other bytes are unchanged; rsp_rdata=0.
- REQ-025 SHALL, for a load, return the full stored word on rsp_rdata; req_be is ignored.
- REQ-026 SHALL set rsp_err=1 and rsp_rdata=0, with no storage write, when addr[1:0]!=0 or when addr is outside BASE_ADDR..BASE_ADDR+4*DEPTH_WORDS-1.
- REQ-027 SHALL compute the range check without wrap-around: an addr below BASE_ADDR is out of range.
- REQ-028 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready=1, then go to IDLE and clear rsp_valid.
- REQ-029 SHALL NOT accept a new request in the cycle of response handshake; req_ready rises the cycle after, so back-to-back throughput is one access per 2+WAIT_CYCLES cycles at minimum.
- REQ-030 SHALL, when a store is followed by a load of the same word, return the stored data (no stale read).

Reset
- REQ-031 SHALL, on an edge with rst=1, enter IDLE with req_ready=1 from the next cycle and rsp_valid=0, rsp_err=0, rsp_rdata=0, wait counter=0.
- REQ-032 SHALL discard any in-flight request when rst is asserted in WAIT; its store SHALL NOT be written.
- REQ-033 SHALL keep storage contents unchanged across reset, since storage is not initialised by rst.
- REQ-034 SHALL give rst priority over every other event in the same cycle.

Verification
- REQ-035 SHALL cover: WAIT_CYCLES=1; store 0xDEADBEEF to BASE+8 with be=0xF, then load BASE+8 -> rsp_valid 2 cycles after each accept, load rdata=0xDEADBEEF, err=0.
- REQ-036 SHALL cover: word at BASE+8 = 0xDEADBEEF, store 0x00005500 with be=0x2, then load -> rdata=0xDEAD55EF.
- REQ-037 SHALL cover: load BASE+6 (misaligned) and load BASE+4*DEPTH_WORDS -> err=1, rdata=0; a following load of the targeted word shows it unchanged.
- REQ-038 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready=0 throughout; req_ready=1 one cycle after rsp_ready=1.
- REQ-039 SHALL cover: WAIT_CYCLES=3, store 0x12345678 to BASE, rst pulsed in the 2nd WAIT cycle -> no rsp_valid, req_ready=1 next cycle, a later load of BASE returns the old value.
- REQ-040 SHALL cover: WAIT_CYCLES=0 -> rsp_valid asserted the cycle right after the accept.
